// File: rtl/alsu_pkg.sv
// Shared opcode, state and flag definitions for the pipelined ALU/shifter.
// Both opcode groups share the 5-bit sub-op field below the group-select bit.
package alsu_pkg;

  localparam int GRP_BIT = 5;

  typedef enum logic [4:0] {
    A_ADD  = 5'd0,
    A_SUB  = 5'd1,
    A_INC  = 5'd2,
    A_DEC  = 5'd3,
    A_ADC  = 5'd4,
    A_SBB  = 5'd5,
    A_NEG  = 5'd6,
    A_PASS = 5'd7,
    A_MUL  = 5'd8
  } arith_op_e;

  typedef enum logic [4:0] {
    L_AND  = 5'd0,
    L_OR   = 5'd1,
    L_XOR  = 5'd2,
    L_NOT  = 5'd3,
    L_NAND = 5'd4,
    L_NOR  = 5'd5,
    L_XNOR = 5'd6,
    L_SHL  = 5'd7,
    L_SHR  = 5'd8,
    L_SAR  = 5'd9,
    L_ROL  = 5'd10,
    L_ROR  = 5'd11
  } logic_op_e;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_MUL_RUN = 1'b1;

  typedef struct packed {
    logic carry;
    logic neg;
    logic zero;
    logic ovf;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alsu_shift_mul.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps.
// 'last' marks the step whose product_next is the final product.
module alsu_shift_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product_next,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign product_next = mplier[0] ? (prod + mcand) : prod;
  assign last         = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      prod   <= '0;
      mplier <= b;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      prod   <= product_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alsu_param_pipe.sv
// ALU/shifter with valid/ready handshakes, accumulator feedback and a registered
// result stage; multiply runs iteratively while the input side is stalled.
//   state      | meaning
//   ST_IDLE    | accepting requests, single-cycle ops complete on accept
//   ST_MUL_RUN | shift-add multiply in progress, in_ready held low
module alsu_param_pipe
  import alsu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       sel,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             neg_flag,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic             illegal_op
);

  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;

  state_t             state;
  logic [WIDTH-1:0]   acc_reg;
  logic               c_reg;
  flags_t             flags_q;

  logic [WIDTH-1:0]   a_eff;
  logic               grp_logic;
  arith_op_e          aop;
  logic_op_e          lop;
  logic [SHW-1:0]     shamt;
  logic               is_mul;
  logic               fire;

  assign a_eff     = acc_en ? acc_reg : a;
  assign grp_logic = sel[GRP_BIT];
  assign aop       = arith_op_e'(sel[4:0]);
  assign lop       = logic_op_e'(sel[4:0]);
  assign shamt     = b[SHW-1:0];
  assign is_mul    = !grp_logic && (aop == A_MUL) && MUL_EN;
  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign fire      = in_valid && in_ready;

  // Every arithmetic op is reduced to x +/- y +/- cin so one adder serves all.
  logic [WIDTH-1:0] x, y;
  logic             cin, sub, arith_legal, arith_ovf;
  logic [WIDTH:0]   ext;

  always_comb begin
    x           = '0;
    y           = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    arith_legal = 1'b1;
    case (aop)
      A_ADD:  begin x = a_eff; y = b; end
      A_SUB:  begin x = a_eff; y = b; sub = 1'b1; end
      A_INC:  begin x = a_eff; y = {{(WIDTH-1){1'b0}}, 1'b1}; end
      A_DEC:  begin x = a_eff; y = {{(WIDTH-1){1'b0}}, 1'b1}; sub = 1'b1; end
      A_ADC:  begin x = a_eff; y = b; cin = c_reg; end
      A_SBB:  begin x = a_eff; y = b; cin = c_reg; sub = 1'b1; end
      A_NEG:  begin y = a_eff; sub = 1'b1; end
      A_PASS: x = a_eff;
      A_MUL:  arith_legal = MUL_EN;
      default: arith_legal = 1'b0;
    endcase
    ext = sub ? ({1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, cin})
              : ({1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin});
    arith_ovf = (sub ? (x[M] != y[M]) : (x[M] == y[M])) && (ext[M] != x[M]);
  end

  logic [WIDTH-1:0]   log_res;
  logic [2*WIDTH-1:0] dbl;
  logic               logic_legal;

  always_comb begin
    log_res     = '0;
    dbl         = '0;
    logic_legal = 1'b1;
    case (lop)
      L_AND:  log_res = a_eff & b;
      L_OR:   log_res = a_eff | b;
      L_XOR:  log_res = a_eff ^ b;
      L_NOT:  log_res = ~a_eff;
      L_NAND: log_res = ~(a_eff & b);
      L_NOR:  log_res = ~(a_eff | b);
      L_XNOR: log_res = ~(a_eff ^ b);
      L_SHL:  log_res = a_eff << shamt;
      L_SHR:  log_res = a_eff >> shamt;
      L_SAR:  log_res = $signed(a_eff) >>> shamt;
      L_ROL:  begin dbl = {a_eff, a_eff} << shamt; log_res = dbl[2*WIDTH-1:WIDTH]; end
      L_ROR:  begin dbl = {a_eff, a_eff} >> shamt; log_res = dbl[WIDTH-1:0]; end
      default: logic_legal = 1'b0;
    endcase
  end

  logic [WIDTH-1:0] res_c;
  flags_t           flg_c;

  always_comb begin
    res_c = '0;
    flg_c = '0;
    if (!grp_logic) begin
      if (arith_legal) begin
        res_c       = ext[M:0];
        flg_c.carry = ext[WIDTH];
        flg_c.ovf   = arith_ovf;
        flg_c.neg   = ext[M];
        flg_c.zero  = (ext[M:0] == '0);
      end else begin
        flg_c.illegal = 1'b1;
      end
    end else if (logic_legal) begin
      res_c      = log_res;
      flg_c.zero = (log_res == '0);
    end else begin
      flg_c.illegal = 1'b1;
    end
  end

  logic [2*WIDTH-1:0] prod_next;
  logic               mul_last;
  logic [WIDTH-1:0]   mul_res;
  flags_t             mul_flags;

  alsu_shift_mul #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (fire && is_mul),
    .a            (a_eff),
    .b            (b),
    .product_next (prod_next),
    .last         (mul_last)
  );

  always_comb begin
    mul_res         = prod_next[M:0];
    mul_flags       = '0;
    mul_flags.carry = |prod_next[2*WIDTH-1:WIDTH];
    mul_flags.neg   = mul_res[M];
    mul_flags.zero  = (mul_res == '0);
  end

  logic wr_fast, wr_mul;
  assign wr_fast = fire && !is_mul;
  assign wr_mul  = (state == ST_MUL_RUN) && mul_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
      c_reg     <= 1'b0;
      acc_reg   <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (fire && is_mul) state <= ST_MUL_RUN;
      end else if (mul_last) begin
        state <= ST_IDLE;
      end

      if (wr_fast) begin
        result    <= res_c;
        flags_q   <= flg_c;
        acc_reg   <= res_c;
        out_valid <= 1'b1;
        if (!grp_logic && arith_legal) c_reg <= flg_c.carry;
      end else if (wr_mul) begin
        result    <= mul_res;
        flags_q   <= mul_flags;
        acc_reg   <= mul_res;
        out_valid <= 1'b1;
        c_reg     <= mul_flags.carry;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign carry_out  = flags_q.carry;
  assign neg_flag   = flags_q.neg;
  assign zero_flag  = flags_q.zero;
  assign ovf_flag   = flags_q.ovf;
  assign illegal_op = flags_q.illegal;

endmodule
